// File: rtl/fm_radio_pkg.sv
// Shared FM radio constants and fixed-point helpers.
// Stream width defaults and sample quantization.
package fm_radio_pkg;

    localparam int FM_DATA_WIDTH = 32;
    localparam int FM_BYTE_WIDTH = 8;
    localparam int FM_BITS       = 10;

    // Sign-extend a 16-bit sample, then scale into fixed point (wraps).
    function automatic logic [FM_DATA_WIDTH-1:0] QUANTIZE(
        input logic [15:0] v
    );
        logic [FM_DATA_WIDTH-1:0] e;
        e = {{(FM_DATA_WIDTH-16){v[15]}}, v};
        return e << FM_BITS;
    endfunction

endpackage

// File: rtl/iq_unpack.sv
// Unpacks a byte stream of I_lo,I_hi,Q_lo,Q_hi into
// paired fixed-point I and Q FIFO writes.
module iq_unpack
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH = FM_DATA_WIDTH,
    parameter int BYTE_WIDTH = FM_BYTE_WIDTH,
    parameter int BITS       = FM_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic                  i_wr_en,
    input  logic                  i_full,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  q_wr_en,
    input  logic                  q_full
);

    localparam int SW = 2 * BYTE_WIDTH;

    typedef enum logic {
        READ,
        WRITE
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [3:0][BYTE_WIDTH-1:0]  bytes_q, bytes_d;

    logic [SW-1:0]               i_raw, q_raw;
    logic [DATA_WIDTH-1:0]       i_ext, q_ext;
    logic [DATA_WIDTH-1:0]       i_quant, q_quant;

    assign i_raw   = {bytes_q[1], bytes_q[0]};
    assign q_raw   = {bytes_q[3], bytes_q[2]};
    assign i_ext   = {{(DATA_WIDTH-SW){i_raw[SW-1]}}, i_raw};
    assign q_ext   = {{(DATA_WIDTH-SW){q_raw[SW-1]}}, q_raw};
    assign i_quant = i_ext << BITS;
    assign q_quant = q_ext << BITS;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= READ;
            cnt_q   <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bytes_d  = bytes_q;
        in_rd_en = 1'b0;
        i_wr_en  = 1'b0;
        q_wr_en  = 1'b0;
        i_out    = '0;
        q_out    = '0;
        if (!reset) begin
            unique case (state_q)
                READ: begin
                    if (!in_empty) begin
                        in_rd_en       = 1'b1;
                        bytes_d[cnt_q] = in_dout;
                        cnt_d          = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    // I and Q always leave together
                    if (!i_full && !q_full) begin
                        i_wr_en = 1'b1;
                        q_wr_en = 1'b1;
                        i_out   = i_quant;
                        q_out   = q_quant;
                        state_d = READ;
                    end
                end
                default: state_d = READ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_unpack.sv
// Bench for iq_unpack: byte-stream source, sample-level
// reference model and per-cycle output checker.
module tb_iq_unpack;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_dout = 8'h00;
    logic        in_empty = 1'b1;
    logic        i_full = 1'b0;
    logic        q_full = 1'b0;
    logic        in_rd_en;
    logic [31:0] i_out;
    logic        i_wr_en;
    logic [31:0] q_out;
    logic        q_wr_en;

    iq_unpack dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .i_out    (i_out),
        .i_wr_en  (i_wr_en),
        .i_full   (i_full),
        .q_out    (q_out),
        .q_wr_en  (q_wr_en),
        .q_full   (q_full)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: 16-bit two's complement value times 2^10, kept to 32 bits
    function automatic logic [31:0] qm(input logic [7:0] lo,
                                       input logic [7:0] hi);
        int v;
        v = int'(shortint'({hi, lo}));
        return 32'(v * 1024);
    endfunction

    logic [7:0]  src[$];
    int          emode = 0;
    int          fmode = 0;
    int          npop = 0;
    int          done = 0;
    bit          tog = 1'b0;

    // Source FIFO model: show-ahead head byte, optional bubbles
    always @(posedge clock) begin
        #1;
        while (done < npop) begin
            if (src.size() != 0) void'(src.pop_front());
            done++;
        end
        tog = ~tog;
        in_empty = (src.size() == 0) || (emode == 1 && tog) ||
                   (emode == 2 && $urandom_range(0, 3) == 0);
        in_dout = (src.size() != 0) ? src[0] : 8'h00;
        if (fmode == 2) begin
            i_full = ($urandom_range(0, 4) == 0);
            q_full = ($urandom_range(0, 4) == 0);
        end
    end

    logic [7:0]  acc[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          writes = 0;
    int          start_cyc = 0;
    int          lat = 0;
    logic [31:0] last_i = 0;
    logic [31:0] last_q = 0;
    bit          pending;
    bit          must_wr;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("rst_rd", {31'd0, in_rd_en}, 32'd0);
            chk("rst_iwr", {31'd0, i_wr_en}, 32'd0);
            chk("rst_qwr", {31'd0, q_wr_en}, 32'd0);
            chk("rst_iout", i_out, 32'd0);
            chk("rst_qout", q_out, 32'd0);
            acc.delete();
            exp_i.delete();
            exp_q.delete();
        end else begin
            chk("pair_wr", {31'd0, i_wr_en}, {31'd0, q_wr_en});
            if (in_rd_en && in_empty)
                chk("rd_while_empty", 32'd1, 32'd0);
            pending = (exp_i.size() != 0);
            if (pending) begin
                must_wr = !i_full && !q_full;
                chk("no_pop_pending", {31'd0, in_rd_en}, 32'd0);
                chk("wr_when_ready", {31'd0, i_wr_en}, {31'd0, must_wr});
            end else begin
                chk("wr_idle", {31'd0, i_wr_en}, 32'd0);
            end
            if (i_wr_en && pending) begin
                chk("i_out", i_out, exp_i[0]);
                chk("q_out", q_out, exp_q[0]);
                void'(exp_i.pop_front());
                void'(exp_q.pop_front());
                writes++;
                last_i = i_out;
                last_q = q_out;
                lat = cyc - start_cyc;
            end else begin
                chk("i_out_zero", i_out, 32'd0);
                chk("q_out_zero", q_out, 32'd0);
            end
            if (in_rd_en && !in_empty) begin
                if (acc.size() == 0) start_cyc = cyc;
                acc.push_back(in_dout);
                npop++;
                if (acc.size() == 4) begin
                    exp_i.push_back(qm(acc[0], acc[1]));
                    exp_q.push_back(qm(acc[2], acc[3]));
                    acc.delete();
                end
            end
        end
    end

    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        src.push_back(a);
        src.push_back(b);
        src.push_back(c);
        src.push_back(d);
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clock);
            #1;
            if (src.size() == 0 && acc.size() == 0 && exp_i.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    int w0;
    int p0;
    bit hit;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state_rd", {31'd0, in_rd_en}, 32'd0);
        chk("rst_state_iout", i_out, 32'd0);
        reset = 1'b0;

        chk("model_pin_a", qm(8'h34, 8'h12), 32'h0048D000);
        chk("model_pin_b", qm(8'hFF, 8'hFF), 32'hFFFFFC00);
        chk("model_pin_c", qm(8'h00, 8'h80), 32'hFE000000);
        chk("model_pin_d", qm(8'hFF, 8'h7F), 32'h01FFFC00);

        // Basic sample, write on 5th cycle
        w0 = writes;
        push4(8'h34, 8'h12, 8'hFF, 8'hFF);
        wait_idle(50);
        chk("t1_writes", writes - w0, 1);
        chk("t1_i", last_i, 32'h0048D000);
        chk("t1_q", last_q, 32'hFFFFFC00);
        chk("t1_lat", lat, 4);

        // Extremes of the 16-bit range
        w0 = writes;
        push4(8'h00, 8'h80, 8'hFF, 8'h7F);
        wait_idle(50);
        chk("t2_writes", writes - w0, 1);
        chk("t2_i", last_i, 32'hFE000000);
        chk("t2_q", last_q, 32'h01FFFC00);
        chk("t2_lat", lat, 4);

        // Bubbly input
        emode = 1;
        w0 = writes;
        push4(8'h01, 8'h00, 8'h02, 8'h00);
        push4(8'hFF, 8'h7F, 8'h00, 8'h80);
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        wait_idle(200);
        chk("t3_writes", writes - w0, 3);
        chk("t3_i", last_i, 32'h0080_4000);
        chk("t3_q", last_q, 32'h0100_C000);
        emode = 0;

        // Q FIFO stalls the write
        @(posedge clock);
        #1;
        q_full = 1'b1;
        w0 = writes;
        push4(8'h78, 8'h56, 8'hCD, 8'hAB);
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            #1;
            if (exp_i.size() != 0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t4_reach_write", {31'd0, hit}, 32'd1);
        p0 = npop;
        repeat (10) @(negedge clock);
        #1;
        chk("t4_stall_writes", writes - w0, 0);
        chk("t4_stall_pops", npop - p0, 0);
        @(posedge clock);
        #1;
        q_full = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("t4_release_writes", writes - w0, 1);
        chk("t4_i", last_i, 32'h0159E000);
        chk("t4_q", last_q, 32'hFEAF3400);
        wait_idle(100);
        chk("t4_total_writes", writes - w0, 2);

        // Reset mid-sample drops partial bytes
        w0 = writes;
        p0 = npop;
        src.push_back(8'hAA);
        src.push_back(8'hBB);
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            #1;
            if (npop - p0 == 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t5_two_pops", {31'd0, hit}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push4(8'h01, 8'h00, 8'h02, 8'h00);
        wait_idle(100);
        chk("t5_writes", writes - w0, 1);
        chk("t5_i", last_i, 32'h00000400);
        chk("t5_q", last_q, 32'h00000800);

        // Random traffic with random stalls
        emode = 2;
        fmode = 2;
        w0 = writes;
        for (int k = 0; k < 4000; k++) src.push_back(8'($urandom));
        wait_idle(40000);
        chk("t6_writes", writes - w0, 1000);
        emode = 0;
        fmode = 0;
        @(posedge clock);
        #1;
        i_full = 1'b0;
        q_full = 1'b0;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
